// File: rtl/lbp_pkg.sv
// Shared types and helpers for the LBP window sequencer.
package lbp_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, EMIT} lbp_state_e;

  localparam int LBP_SEL_W = 4;

  function automatic int lbp_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/lbp_code_shift.sv
// N_NEIGH-bit shift-in collector: first captured bit ends up as the MSB.
module lbp_code_shift
  import lbp_pkg::*;
#(
  parameter int N_NEIGH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               cap_en,
  input  logic               bit_in,
  output logic [N_NEIGH-1:0] code
);

  logic [N_NEIGH-1:0] code_q;
  logic [N_NEIGH-1:0] code_d;

  always_comb begin
    code_d = code_q;
    if (clr) begin
      code_d = '0;
    end else if (cap_en) begin
      code_d = N_NEIGH'({code_q, bit_in});
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      code_q <= '0;
    end else begin
      code_q <= code_d;
    end
  end

  assign code = code_q;

endmodule

// File: rtl/lbp_window_seq.sv
// LBP window sequencer: streams neighbours into the dual-channel comparison
// stage and gathers its result bits into two codes. Optional cross-check: LBP_SEQ_XCHK_EN.
module lbp_window_seq
  import lbp_pkg::*;
#(
  parameter int N_NEIGH = 8,
  parameter int PIX_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  input  logic [PIX_W-1:0]     pix_data,
  input  logic [LBP_SEL_W-1:0] cfg_sel1,
  input  logic [LBP_SEL_W-1:0] cfg_sel2,
  input  logic                 cfg_minmax,
  output logic [PIX_W-1:0]     oc_x,
  output logic [LBP_SEL_W-1:0] oc_sel1,
  output logic [LBP_SEL_W-1:0] oc_sel2,
  output logic                 oc_minmax,
  output logic                 oc_clr,
  input  logic                 oc_out1,
  input  logic                 oc_out2,
  output logic                 code_valid,
  input  logic                 code_ready,
  output logic [N_NEIGH-1:0]   code1,
  output logic [N_NEIGH-1:0]   code2,
  output logic                 code_err
);

  localparam int CW = lbp_cnt_w(N_NEIGH);

  lbp_state_e           state_q, state_d;
  logic [CW-1:0]        acc_cnt_q, acc_cnt_d;
  logic [CW-1:0]        cap_cnt_q, cap_cnt_d;
  logic                 v1_q, v1_d, v2_q, v2_d;
  logic                 pix_ready_q, pix_ready_d;
  logic [PIX_W-1:0]     oc_x_q, oc_x_d;
  logic [LBP_SEL_W-1:0] oc_sel1_q, oc_sel1_d, oc_sel2_q, oc_sel2_d;
  logic                 oc_minmax_q, oc_minmax_d;
  logic                 oc_clr_q, oc_clr_d;
  logic                 code_valid_q, code_valid_d;
  logic                 accept, cap_en, clr_codes;
`ifdef LBP_SEQ_XCHK_EN
  logic                 code_err_q, code_err_d;
  logic [N_NEIGH:0]     shift1, shift2;
  assign shift1 = {code1, oc_out1};
  assign shift2 = {code2, oc_out2};
`endif

  always_comb begin
    state_d      = state_q;
    acc_cnt_d    = acc_cnt_q;
    cap_cnt_d    = cap_cnt_q;
    oc_x_d       = oc_x_q;
    oc_sel1_d    = oc_sel1_q;
    oc_sel2_d    = oc_sel2_q;
    oc_minmax_d  = oc_minmax_q;
    clr_codes    = 1'b0;
`ifdef LBP_SEQ_XCHK_EN
    code_err_d   = code_err_q;
`endif
    accept = pix_valid && pix_ready_q;
    // Only cycles two beats after an accept carry a live stage result.
    cap_en = v2_q && (state_q == RUN || state_q == DRAIN);
    v1_d   = accept;
    v2_d   = v1_q;
    if (accept) oc_x_d = pix_data;
    if (cap_en) cap_cnt_d = cap_cnt_q + 1'b1;

    case (state_q)
      IDLE: if (accept) begin
        oc_sel1_d   = cfg_sel1;
        oc_sel2_d   = cfg_sel2;
        oc_minmax_d = cfg_minmax;
        acc_cnt_d   = '0;
        cap_cnt_d   = '0;
        clr_codes   = 1'b1;
`ifdef LBP_SEQ_XCHK_EN
        code_err_d  = 1'b0;
`endif
        state_d     = (N_NEIGH == 1) ? DRAIN : RUN;
      end
      RUN: if (accept) begin
        acc_cnt_d = acc_cnt_q + 1'b1;
        if (acc_cnt_d == CW'(N_NEIGH - 1)) state_d = DRAIN;
      end
      DRAIN: if (cap_en && cap_cnt_d == CW'(N_NEIGH)) begin
        state_d = EMIT;
`ifdef LBP_SEQ_XCHK_EN
        code_err_d = !oc_minmax_q && (shift1[N_NEIGH-1:0] != shift2[N_NEIGH-1:0]);
`endif
      end
      EMIT: if (code_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    pix_ready_d  = (state_d == IDLE) || (state_d == RUN);
    code_valid_d = (state_d == EMIT);
    oc_clr_d     = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      acc_cnt_q    <= '0;
      cap_cnt_q    <= '0;
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      pix_ready_q  <= 1'b0;
      oc_x_q       <= '0;
      oc_sel1_q    <= '0;
      oc_sel2_q    <= '0;
      oc_minmax_q  <= 1'b0;
      oc_clr_q     <= 1'b1;
      code_valid_q <= 1'b0;
`ifdef LBP_SEQ_XCHK_EN
      code_err_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      acc_cnt_q    <= acc_cnt_d;
      cap_cnt_q    <= cap_cnt_d;
      v1_q         <= v1_d;
      v2_q         <= v2_d;
      pix_ready_q  <= pix_ready_d;
      oc_x_q       <= oc_x_d;
      oc_sel1_q    <= oc_sel1_d;
      oc_sel2_q    <= oc_sel2_d;
      oc_minmax_q  <= oc_minmax_d;
      oc_clr_q     <= oc_clr_d;
      code_valid_q <= code_valid_d;
`ifdef LBP_SEQ_XCHK_EN
      code_err_q   <= code_err_d;
`endif
    end
  end

  lbp_code_shift #(.N_NEIGH(N_NEIGH)) u_shift1 (
    .clk(clk), .reset(reset), .clr(clr_codes), .cap_en(cap_en), .bit_in(oc_out1), .code(code1)
  );
  lbp_code_shift #(.N_NEIGH(N_NEIGH)) u_shift2 (
    .clk(clk), .reset(reset), .clr(clr_codes), .cap_en(cap_en), .bit_in(oc_out2), .code(code2)
  );

  assign pix_ready  = pix_ready_q;
  assign oc_x       = oc_x_q;
  assign oc_sel1    = oc_sel1_q;
  assign oc_sel2    = oc_sel2_q;
  assign oc_minmax  = oc_minmax_q;
  assign oc_clr     = oc_clr_q;
  assign code_valid = code_valid_q;
`ifdef LBP_SEQ_XCHK_EN
  assign code_err   = code_err_q;
`else
  assign code_err   = 1'b0;
`endif

endmodule

// File: tb/tb_lbp_window_seq.sv
// Self-checking bench for lbp_window_seq with a behavioural comparison-stage model.
module tb_lbp_window_seq;

  localparam int N = 8;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         pix_valid = 1'b0;
  logic         pix_ready;
  logic [W-1:0] pix_data = '0;
  logic [3:0]   cfg_sel1 = '0, cfg_sel2 = '0;
  logic         cfg_minmax = 1'b0;
  logic [W-1:0] oc_x;
  logic [3:0]   oc_sel1, oc_sel2;
  logic         oc_minmax, oc_clr;
  logic         oc_out1, oc_out2;
  logic         code_valid;
  logic         code_ready = 1'b0;
  logic [N-1:0] code1, code2;
  logic         code_err;

  int tests = 0;
  int fails = 0;
  int ch2_mode = 0;

  lbp_window_seq #(.N_NEIGH(N), .PIX_W(W)) dut (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .cfg_sel1(cfg_sel1), .cfg_sel2(cfg_sel2), .cfg_minmax(cfg_minmax),
    .oc_x(oc_x), .oc_sel1(oc_sel1), .oc_sel2(oc_sel2), .oc_minmax(oc_minmax), .oc_clr(oc_clr),
    .oc_out1(oc_out1), .oc_out2(oc_out2), .code_valid(code_valid), .code_ready(code_ready),
    .code1(code1), .code2(code2), .code_err(code_err)
  );

  always #5 clk = ~clk;

  function automatic logic stage1(input logic [W-1:0] x);
    return x > 8'h80;
  endfunction

  // mode 0: same rule as channel 1; mode 1: inverts only sample 0x81; mode 2: x < 0x40
  function automatic logic stage2(input logic [W-1:0] x, input int mode);
    if (mode == 1) return (x > 8'h80) ^ (x == 8'h81);
    if (mode == 2) return x < 8'h40;
    return x > 8'h80;
  endfunction

  // Comparison stage: registered results, cleared by oc_clr.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      oc_out1 <= 1'b0;
      oc_out2 <= 1'b0;
    end else if (oc_clr) begin
      oc_out1 <= 1'b0;
      oc_out2 <= 1'b0;
    end else begin
      oc_out1 <= stage1(oc_x);
      oc_out2 <= stage2(oc_x, ch2_mode);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, need %0h", tag, obs, exp);
    end
  endtask

  // bubble: 0 none, 1 every other cycle, 2 random ~30%
  task automatic run_window(input logic [W-1:0] s [N], input int bubble, input int hold,
                            input logic [3:0] sel1, input logic [3:0] sel2, input logic mm,
                            input bit cfg_change, input bit chk_first);
    logic [N-1:0] e1, e2;
    logic         eerr;
    int idx = 0, cyc = 0, first_cyc = -1, last_cyc = -1;
    int drops = 0, cfg_bad = 0, clr_bad = 0, acc_bad = 0, hold_bad = 0;
    bit skip;
    for (int k = 0; k < N; k++) begin
      e1[N-1-k] = stage1(s[k]);
      e2[N-1-k] = stage2(s[k], ch2_mode);
    end
`ifdef LBP_SEQ_XCHK_EN
    eerr = !mm && (e1 != e2);
`else
    eerr = 1'b0;
`endif
    cfg_sel1 = sel1; cfg_sel2 = sel2; cfg_minmax = mm;
    while (idx < N && cyc < 200) begin
      @(negedge clk); cyc++;
      if (first_cyc >= 0) begin
        if (pix_ready !== 1'b1) drops++;
        if (oc_sel1 !== sel1 || oc_sel2 !== sel2 || oc_minmax !== mm) cfg_bad++;
        if (oc_clr !== 1'b0) clr_bad++;
        if (cfg_change) begin
          cfg_sel1 = 4'd9; cfg_sel2 = ~sel2; cfg_minmax = ~mm;
        end
      end
      skip = (bubble == 1 && cyc[0]) || (bubble == 2 && $urandom_range(99) < 30);
      if (skip) begin
        pix_valid = 1'b0;
        pix_data  = $urandom;
      end else begin
        pix_valid = 1'b1;
        pix_data  = s[idx];
        if (pix_ready === 1'b1) begin
          if (first_cyc < 0) first_cyc = cyc;
          last_cyc = cyc;
          idx++;
        end
      end
    end
    // Junk keeps pix_valid high: nothing may be taken while draining or emitting.
    do begin
      @(negedge clk); cyc++;
      pix_valid = 1'b1; pix_data = 8'h55;
      if (pix_ready !== 1'b0) acc_bad++;
      if (oc_sel1 !== sel1 || oc_sel2 !== sel2 || oc_minmax !== mm) cfg_bad++;
    end while (code_valid !== 1'b1 && cyc < last_cyc + 50);
    check("code_valid_rise", code_valid, 1'b1);
    check("lat_last_accept", cyc - last_cyc, 3);
    if (chk_first) check("lat_first_accept", cyc - first_cyc, 10);
    check("ready_in_run", drops, 0);
    check("cfg_held", cfg_bad, 0);
    check("clr_low_in_window", clr_bad, 0);
    check("code1", code1, e1);
    check("code2", code2, e2);
    check("code_err", code_err, eerr);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (code_valid !== 1'b1 || code1 !== e1 || code2 !== e2 || code_err !== eerr) hold_bad++;
      if (pix_ready !== 1'b0) acc_bad++;
    end
    check("emit_stable", hold_bad, 0);
    check("no_accept_after_last", acc_bad, 0);
    code_ready = 1'b1;
    @(negedge clk);
    code_ready = 1'b0;
    pix_valid  = 1'b0;
    check("post_hs_valid", code_valid, 1'b0);
    check("post_hs_ready", pix_ready, 1'b1);
    check("post_hs_clr", oc_clr, 1'b1);
    $display("[TB] window code1=%02h code2=%02h err=%0b bubble=%0d hold=%0d", code1, code2, code_err, bubble, hold);
  endtask

  initial begin
    logic [W-1:0] fw [N];
    logic [W-1:0] rw [N];
    int idx, guard;
    fw = '{8'h90, 8'h10, 8'hFF, 8'h00, 8'h81, 8'h80, 8'hA0, 8'h01};

    repeat (3) @(negedge clk);
    check("rst_pix_ready", pix_ready, 1'b0);
    check("rst_oc_clr", oc_clr, 1'b1);
    check("rst_code_valid", code_valid, 1'b0);
    check("rst_codes", {code1, code2}, 16'h0);
    check("rst_oc", {oc_x, oc_sel1, oc_sel2, oc_minmax, code_err}, '0);
    reset = 1'b0;

    run_window(fw, 0, 0, 4'd3, 4'd5, 1'b0, 1'b0, 1'b1);
    run_window(fw, 1, 0, 4'd3, 4'd5, 1'b0, 1'b0, 1'b0);
    run_window(fw, 0, 5, 4'd3, 4'd5, 1'b0, 1'b0, 1'b1);
    run_window(fw, 1, 2, 4'd3, 4'd7, 1'b1, 1'b1, 1'b0);
    run_window(fw, 0, 0, 4'd9, 4'd1, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of a window.
    idx = 0; guard = 0;
    while (idx < 4 && guard < 50) begin
      @(negedge clk); guard++;
      pix_valid = 1'b1; pix_data = 8'hF0;
      if (pix_ready === 1'b1) idx++;
    end
    @(negedge clk);
    reset = 1'b1; pix_valid = 1'b0;
    @(negedge clk);
    check("midrst_pix_ready", pix_ready, 1'b0);
    check("midrst_oc_clr", oc_clr, 1'b1);
    check("midrst_code_valid", code_valid, 1'b0);
    check("midrst_codes", {code1, code2}, 16'h0);
    reset = 1'b0;
    run_window(fw, 0, 0, 4'd2, 4'd2, 1'b0, 1'b0, 1'b1);

    ch2_mode = 1;
    run_window(fw, 0, 1, 4'd3, 4'd3, 1'b0, 1'b0, 1'b1);
    run_window(fw, 0, 1, 4'd3, 4'd3, 1'b1, 1'b0, 1'b1);

    for (int w = 0; w < 20; w++) begin
      for (int k = 0; k < N; k++) rw[k] = $urandom;
      ch2_mode = $urandom_range(2);
      run_window(rw, $urandom_range(2), $urandom_range(3), 4'($urandom), 4'($urandom),
                 1'($urandom), 1'($urandom), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
